truth_table_sequencer: RTL and testbench

//   Sequential exhaustive-sweep controller for a 4-input combinational function block (A,B,C,D -> F).
//   On start it drives every input combination 0000..1111 (A = MSB), waits a settle time, samples F,
//   and compares the result against a 16-bit expected truth table.

---
 rtl/truth_table_sequencer_pkg.sv | 21 ++
 rtl/truth_table_sequencer_settle_counter.sv | 36 +++
 rtl/truth_table_sequencer.sv | 134 +++++++++++++
 tb/tb_truth_table_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sweep controller: FSM state encoding,
// default parameters and the settle-counter reload helper.
package truth_table_sequencer_pkg;

    localparam int N_IN_DEF       = 4;
    localparam int SETTLE_CYC_DEF = 1;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // The counter counts down to zero, so a hold of N cycles reloads N-1.
    function automatic logic [CNT_W-1:0] settleReload(input int settleCyc);
        return CNT_W'(settleCyc - 1);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_counter.sv
// Down-counter that times how long each vector is held before sampling.
// Load has priority over decrement; the counter stops at zero.
module settle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Exhaustive-sweep controller: walks every input vector of a 4-input function,
// samples F after a settle time and compares the result to a golden truth table.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx
);

    localparam int              DEPTH    = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [DEPTH-1:0]  expected_q, expected_d;
    logic [DEPTH-1:0]  captured_q, captured_d;
    logic [N_IN:0]     errCount_q, errCount_d;
    logic [N_IN-1:0]   firstErr_q, firstErr_d;
    logic              pass_q, pass_d;
    logic              cntLoad, cntDec, cntZero;
    logic              accept, lastIdx;

    assign accept  = (state_q == S_IDLE) && start;
    assign lastIdx = (idx_q == LAST_IDX);

    settle_counter #(
        .WIDTH (CNT_W)
    ) u_settle (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cntLoad),
        .dec_i      (cntDec),
        .load_val_i (settleReload(SETTLE_CYC)),
        .zero_o     (cntZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_SETTLE;
            S_SETTLE: if (cntZero) state_d = S_SAMPLE;
            S_SAMPLE: state_d = lastIdx ? S_DONE : S_SETTLE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        cntLoad = accept || ((state_q == S_SAMPLE) && !lastIdx);
        cntDec  = (state_q == S_SETTLE);
    end

    // Result registers are cleared on accept and otherwise only move in SAMPLE,
    // so they hold through DONE and IDLE until the next sweep starts.
    always_comb begin
        idx_d      = idx_q;
        expected_d = expected_q;
        captured_d = captured_q;
        errCount_d = errCount_q;
        firstErr_d = firstErr_q;
        pass_d     = pass_q;
        if (accept) begin
            idx_d      = '0;
            expected_d = expected;
            captured_d = '0;
            errCount_d = '0;
            firstErr_d = '0;
            pass_d     = 1'b0;
        end else if (state_q == S_SAMPLE) begin
            captured_d[idx_q] = f_in;
            if (f_in != expected_q[idx_q]) begin
                errCount_d = errCount_q + ERR_ONE;
                if (errCount_q == '0) begin
                    firstErr_d = idx_q;
                end
            end
            if (lastIdx) begin
                pass_d = (errCount_d == '0);
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            expected_q <= '0;
            captured_q <= '0;
            errCount_q <= '0;
            firstErr_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            expected_q <= expected_d;
            captured_q <= captured_d;
            errCount_q <= errCount_d;
            firstErr_q <= firstErr_d;
            pass_q     <= pass_d;
        end
    end

    assign vec_out       = idx_q;
    assign captured      = captured_q;
    assign err_count     = errCount_q;
    assign first_err_idx = firstErr_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer: directed and randomized sweeps
// against a stub function-under-test and a table-level reference model.
module tb_truth_table_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2;
    logic [15:0] expected1, expected2;
    logic        f1, f2;
    logic [3:0]  vec1, vec2;
    logic        busy1, busy2, done1, done2, pass1, pass2;
    logic [15:0] captured1, captured2;
    logic [4:0]  errCount1, errCount2;
    logic [3:0]  firstErr1, firstErr2;

    logic [15:0] stubTable1, invMask1, stubTable2;
    logic [3:0]  vecDly2a, vecDly2b;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    truth_table_sequencer #(.N_IN(4), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expected1), .f_in(f1),
        .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(captured1), .err_count(errCount1), .first_err_idx(firstErr1)
    );

    truth_table_sequencer #(.N_IN(4), .SETTLE_CYC(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .expected(expected2), .f_in(f2),
        .vec_out(vec2), .busy(busy2), .done(done2), .pass(pass2),
        .captured(captured2), .err_count(errCount2), .first_err_idx(firstErr2)
    );

    // Stub 1 answers instantly, optionally inverting selected vectors;
    // stub 2 answers two clocks after its vector changes.
    assign f1 = stubTable1[vec1] ^ invMask1[vec1];
    assign f2 = stubTable2[vecDly2b];

    always @(posedge clk) begin
        vecDly2a <= vec2;
        vecDly2b <= vecDly2a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expectedVal);
        checkCount++;
        assert (observed === expectedVal) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expectedVal);
        end
    endtask

    // Reference: the captured table is whatever the stub answers per vector;
    // mismatches are exactly the inverted vectors.
    task automatic modelSweep(input logic [15:0] tt, input logic [15:0] mask,
                              output logic [15:0] mCap, output logic [4:0] mErr,
                              output logic [3:0] mFirst, output logic mPass);
        bit found = 0;
        mCap   = tt ^ mask;
        mErr   = '0;
        mFirst = '0;
        for (int i = 0; i < 16; i++) begin
            if (mCap[i] != tt[i]) begin
                mErr = mErr + 5'd1;
                if (!found) begin
                    mFirst = 4'(i);
                    found  = 1;
                end
            end
        end
        mPass = (mCap == tt);
    endtask

    task automatic checkResults1(input string tag, input logic [15:0] tt, input logic [15:0] mask);
        logic [15:0] mCap;
        logic [4:0]  mErr;
        logic [3:0]  mFirst;
        logic        mPass;
        modelSweep(tt, mask, mCap, mErr, mFirst, mPass);
        checkOutput({tag, " pass"}, 32'(pass1), 32'(mPass));
        checkOutput({tag, " captured"}, 32'(captured1), 32'(mCap));
        checkOutput({tag, " err_count"}, 32'(errCount1), 32'(mErr));
        checkOutput({tag, " first_err_idx"}, 32'(firstErr1), 32'(mFirst));
    endtask

    task automatic applyStimulus(input string tag, input logic [15:0] tt, input logic [15:0] mask, input int changeAt);
        int lat;
        stubTable1 = tt;
        invMask1   = mask;
        expected1  = tt;
        start1     = 1'b1;
        tick();
        start1 = 1'b0;
        checkOutput({tag, " busy after accept"}, 32'(busy1), 32'd1);
        lat = 0;
        while (done1 !== 1'b1 && lat < 200) begin
            if (lat == changeAt) expected1 = 16'h0000;
            tick();
            lat++;
        end
        checkOutput({tag, " done latency"}, 32'(lat), 32'd32);
        checkResults1(tag, tt, mask);
        tick();
        checkOutput({tag, " done cleared"}, 32'(done1), 32'd0);
        checkOutput({tag, " busy cleared"}, 32'(busy1), 32'd0);
        checkResults1({tag, " held"}, tt, mask);
    endtask

    task automatic checkAllZero1(input string tag);
        checkOutput({tag, " vec_out"}, 32'(vec1), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy1), 32'd0);
        checkOutput({tag, " done"}, 32'(done1), 32'd0);
        checkOutput({tag, " pass"}, 32'(pass1), 32'd0);
        checkOutput({tag, " captured"}, 32'(captured1), 32'd0);
        checkOutput({tag, " err_count"}, 32'(errCount1), 32'd0);
        checkOutput({tag, " first_err_idx"}, 32'(firstErr1), 32'd0);
    endtask

    initial begin
        int          lat;
        int          doneSeen;
        int          busySeen;
        logic [15:0] tt, mask;

        rst        = 1'b1;
        start1     = 1'b0;
        start2     = 1'b0;
        expected1  = '0;
        expected2  = '0;
        stubTable1 = '0;
        invMask1   = '0;
        stubTable2 = '0;
        tick();
        tick();
        rst = 1'b0;
        checkAllZero1("reset");

        // Case 1 (with the expected port cleared mid-sweep) and case 2.
        applyStimulus("case1", 16'hA5C3, 16'h0000, 12);
        applyStimulus("case2", 16'hA5C3, 16'h1020, -1);
        checkOutput("case2 captured literal", 32'(captured1), 32'h0000B5E3);

        // Boundaries: every vector wrong, and only the last vector wrong.
        applyStimulus("allwrong", 16'h1234, 16'hFFFF, -1);
        applyStimulus("lastwrong", 16'h0F0F, 16'h8000, -1);

        // Randomized tables and fault masks.
        for (int r = 0; r < 4; r++) begin
            tt   = 16'($urandom);
            mask = (r == 0) ? 16'h0000 : 16'($urandom) & 16'($urandom);
            applyStimulus($sformatf("rand%0d", r), tt, mask, -1);
        end

        // Case 3: start re-pulsed at e10 and in DONE is ignored.
        stubTable1 = 16'h3C5A;
        invMask1   = '0;
        expected1  = 16'h3C5A;
        start1     = 1'b1;
        tick();
        start1   = 1'b0;
        doneSeen = 0;
        checkOutput("case3 vec j0", 32'(vec1), 32'd0);
        for (int j = 1; j <= 45; j++) begin
            start1 = (j == 10 || j == 33);
            tick();
            if (done1 === 1'b1) doneSeen++;
            checkOutput($sformatf("case3 vec j%0d", j), 32'(vec1), (j / 2 > 15) ? 32'd15 : 32'(j / 2));
        end
        start1 = 1'b0;
        checkOutput("case3 done pulses", 32'(doneSeen), 32'd1);
        checkOutput("case3 busy idle", 32'(busy1), 32'd0);

        // Case 4: reset at e20 aborts the sweep without a done pulse.
        stubTable1 = 16'hA5C3;
        expected1  = 16'hA5C3;
        start1     = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 1; j < 20; j++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkAllZero1("case4 after rst");
        doneSeen = 0;
        busySeen = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (done1 === 1'b1) doneSeen++;
            if (busy1 === 1'b1) busySeen++;
        end
        checkOutput("case4 no done", 32'(doneSeen), 32'd0);
        checkOutput("case4 stays idle", 32'(busySeen), 32'd0);
        applyStimulus("case4 rerun", 16'hA5C3, 16'h0000, -1);

        // Case 5: longer settle with a slow stub.
        stubTable2 = 16'h6E29;
        expected2  = 16'h6E29;
        start2     = 1'b1;
        tick();
        start2 = 1'b0;
        lat    = 0;
        while (done2 !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
        checkOutput("case5 done latency", 32'(lat), 32'd64);
        checkOutput("case5 pass", 32'(pass2), 32'd1);
        checkOutput("case5 captured", 32'(captured2), 32'h00006E29);
        checkOutput("case5 err_count", 32'(errCount2), 32'd0);

        // Case 6: start held high gives back-to-back sweeps.
        stubTable1 = 16'hC0DE;
        invMask1   = 16'h0240;
        expected1  = 16'hC0DE;
        start1     = 1'b1;
        tick();
        lat = 0;
        while (done1 !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        checkOutput("case6 first done", 32'(lat), 32'd32);
        checkResults1("case6 run1", 16'hC0DE, 16'h0240);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (done1 !== 1'b1 && lat < 200);
        checkOutput("case6 second done", 32'(lat), 32'd34);
        checkResults1("case6 run2", 16'hC0DE, 16'h0240);
        start1 = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
